// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory scheduling arbiter.
package mem_arb_pkg;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_e;
endpackage

// File: rtl/mem_sched_arbiter_if.sv
// Cache-side and adaptor-side signals of the arbiter.
// slave: arbiter view; master: environment (caches + adaptor) view.
interface mem_sched_arbiter_if;
    import mem_arb_pkg::*;

    logic              inst_mem_read;
    logic [ADDR_W-1:0] inst_mem_addr;
    logic [LINE_W-1:0] inst_mem_rdata;
    logic              inst_mem_resp;

    logic              data_mem_read;
    logic              data_mem_write;
    logic [ADDR_W-1:0] data_mem_addr;
    logic [LINE_W-1:0] data_mem_wdata;
    logic [LINE_W-1:0] data_mem_rdata;
    logic              data_mem_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  inst_mem_read, inst_mem_addr,
        input  data_mem_read, data_mem_write, data_mem_addr, data_mem_wdata,
        input  mem_rdata, mem_resp,
        output inst_mem_rdata, inst_mem_resp,
        output data_mem_rdata, data_mem_resp,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output inst_mem_read, inst_mem_addr,
        output data_mem_read, data_mem_write, data_mem_addr, data_mem_wdata,
        output mem_rdata, mem_resp,
        input  inst_mem_rdata, inst_mem_resp,
        input  data_mem_rdata, data_mem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// Counts data grants issued while an instruction fill is waiting.
// Saturates at STARVE_LIMIT; at_limit tells the arbiter to favour the I-side.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    // Saturating counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   cnt <= '0;
        else if (clr)                   cnt <= '0;
        else if (inc && (cnt != LIMIT)) cnt <= cnt + 1'b1;
    end

    assign at_limit = (cnt == LIMIT);
endmodule

// File: rtl/mem_sched_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one cacheline
// adaptor. Data side has priority; a RECOVER cycle follows every completion.
// Optional build macro: ARB_STARVE_GUARD_EN -- after STARVE_LIMIT consecutive
// data grants with an instruction fill waiting, the I-side is served next.
module mem_sched_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_sched_arbiter_if.slave bus
);
    arb_state_e        state, state_nxt;
    logic              data_pend, inst_pend, inst_first;
    logic              grant_i, grant_d, done;
    logic              rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    assign data_pend = bus.data_mem_read | bus.data_mem_write;
    assign inst_pend = bus.inst_mem_read;
    // mem_resp only counts while a grant is outstanding
    assign done      = ((state == GRANT_I) || (state == GRANT_D)) && bus.mem_resp;

`ifdef ARB_STARVE_GUARD_EN
    logic starved;

    arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (grant_d && inst_pend),
        .clr      (grant_i || ((state == IDLE) && !inst_pend)),
        .at_limit (starved)
    );

    assign inst_first = starved & inst_pend;
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign inst_first = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and grant decision.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (inst_first)     grant_i = 1'b1;
                else if (data_pend) grant_d = 1'b1;
                else if (inst_pend) grant_i = 1'b1;
                if (grant_d)        state_nxt = GRANT_D;
                else if (grant_i)   state_nxt = GRANT_I;
            end
            GRANT_I, GRANT_D: if (bus.mem_resp) state_nxt = RECOVER;
            RECOVER:          state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    // Request registers: latched on grant, dropped after the completion cycle.
    // A simultaneous read+write from the D-side is issued as a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_d) begin
            rd_q    <= ~bus.data_mem_write;
            wr_q    <= bus.data_mem_write;
            addr_q  <= bus.data_mem_addr;
            wdata_q <= bus.data_mem_wdata;
        end else if (grant_i) begin
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= bus.inst_mem_addr;
            wdata_q <= '0;
        end else if (done) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end
    end

    assign bus.mem_read       = rd_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.inst_mem_resp  = (state == GRANT_I) & bus.mem_resp;
    assign bus.data_mem_resp  = (state == GRANT_D) & bus.mem_resp;
    assign bus.inst_mem_rdata = bus.mem_rdata;
    assign bus.data_mem_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_sched_arbiter.sv
// Directed bench for mem_sched_arbiter with an expected-grant scoreboard.
module tb_mem_sched_arbiter;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    typedef struct {
        logic         is_inst;
        logic         is_wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } exp_t;

    exp_t sb[$];

    mem_sched_arbiter_if ifc ();

    mem_sched_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_inst, input logic is_wr, input logic [31:0] a,
                        input logic [255:0] wd);
        exp_t e;
        e.is_inst = is_inst;
        e.is_wr   = is_wr;
        e.addr    = a;
        e.wdata   = wd;
        sb.push_back(e);
    endtask

    // Wait for the next adaptor request, compare it against the scoreboard,
    // answer after lat cycles with rd, then check the RECOVER cycle.
    task automatic serve(input int lat, input logic [255:0] rd, input bit drop);
        exp_t e;
        int   n;
        n = 0;
        while (!(ifc.mem_read || ifc.mem_write) && n < 20) begin
            tick();
            n++;
        end
        chk("grant_wait", n < 20, 1'b1);
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("op_rd", ifc.mem_read, !e.is_wr);
        chk("op_wr", ifc.mem_write, e.is_wr);
        chk("addr", ifc.mem_address, e.addr);
        chk("wdata", ifc.mem_wdata, e.wdata);
        repeat (lat) begin
            tick();
            chk("hold_rd", ifc.mem_read, !e.is_wr);
            chk("hold_addr", ifc.mem_address, e.addr);
            chk("early_resp", {ifc.inst_mem_resp, ifc.data_mem_resp}, 2'b00);
        end
        ifc.mem_resp  = 1'b1;
        ifc.mem_rdata = rd;
        if (drop) begin
            if (e.is_inst) ifc.inst_mem_read = 1'b0;
            else begin
                ifc.data_mem_read  = 1'b0;
                ifc.data_mem_write = 1'b0;
            end
        end
        #1;
        chk("i_resp", ifc.inst_mem_resp, e.is_inst);
        chk("d_resp", ifc.data_mem_resp, !e.is_inst);
        chk("rdata", e.is_inst ? ifc.inst_mem_rdata : ifc.data_mem_rdata, rd);
        tick();
        ifc.mem_resp = 1'b0;
        #1;
        chk("rec_req", ifc.mem_read | ifc.mem_write, 1'b0);
        chk("rec_resp", ifc.inst_mem_resp | ifc.data_mem_resp, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        ifc.inst_mem_read  = 1'b0;
        ifc.inst_mem_addr  = '0;
        ifc.data_mem_read  = 1'b0;
        ifc.data_mem_write = 1'b0;
        ifc.data_mem_addr  = '0;
        ifc.data_mem_wdata = '0;
        ifc.mem_rdata      = '0;
        ifc.mem_resp       = 1'b0;
        #1;
        chk("rst_rd", ifc.mem_read, 1'b0);
        chk("rst_wr", ifc.mem_write, 1'b0);
        chk("rst_addr", ifc.mem_address, 32'h0);
        chk("rst_wdata", ifc.mem_wdata, 256'h0);
        chk("rst_iresp", ifc.inst_mem_resp, 1'b0);
        chk("rst_dresp", ifc.data_mem_resp, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Lone instruction fill: request visible one cycle later, 3-cycle memory
        ifc.inst_mem_read = 1'b1;
        ifc.inst_mem_addr = 32'h0000_0060;
        push(1'b1, 1'b0, 32'h60, 256'h0);
        tick();
        chk("i_latency", ifc.mem_read, 1'b1);
        serve(3, {8{32'hAAAA_AAAA}}, 1'b1);
        tick();

        // Simultaneous requests: data first, then instruction
        ifc.inst_mem_read = 1'b1;
        ifc.inst_mem_addr = 32'h100;
        ifc.data_mem_read = 1'b1;
        ifc.data_mem_addr = 32'h200;
        push(1'b0, 1'b0, 32'h200, 256'h0);
        push(1'b1, 1'b0, 32'h100, 256'h0);
        serve(2, {8{32'h1111_1111}}, 1'b1);
        chk("rec_no_grant", ifc.mem_read, 1'b0);
        serve(2, {8{32'h2222_2222}}, 1'b1);
        tick();

        // Read and write together is a writeback
        ifc.data_mem_read  = 1'b1;
        ifc.data_mem_write = 1'b1;
        ifc.data_mem_addr  = 32'h400;
        ifc.data_mem_wdata = {8{32'h5555_5555}};
        push(1'b0, 1'b1, 32'h400, {8{32'h5555_5555}});
        serve(1, 256'h0, 1'b1);
        ifc.data_mem_wdata = '0;
        tick();

        // Requester drops mid-grant; transaction still completes
        ifc.data_mem_read = 1'b1;
        ifc.data_mem_addr = 32'h500;
        push(1'b0, 1'b0, 32'h500, 256'h0);
        tick();
        chk("drop_granted", ifc.mem_read, 1'b1);
        ifc.data_mem_read = 1'b0;
        serve(3, {8{32'h3333_3333}}, 1'b1);
        tick();

        // Reset in the middle of a data grant
        ifc.data_mem_read = 1'b1;
        ifc.data_mem_addr = 32'h300;
        tick();
        chk("rst_mid_pre", ifc.mem_read, 1'b1);
        tick();
        reset_n = 1'b0;
        ifc.data_mem_read = 1'b0;
        #1;
        chk("rst_mid_rd", ifc.mem_read, 1'b0);
        chk("rst_mid_addr", ifc.mem_address, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        ifc.mem_resp  = 1'b1;
        ifc.mem_rdata = {8{32'h4444_4444}};
        #1;
        chk("late_dresp", ifc.data_mem_resp, 1'b0);
        chk("late_iresp", ifc.inst_mem_resp, 1'b0);
        tick();
        ifc.mem_resp = 1'b0;
        chk("late_no_req", ifc.mem_read | ifc.mem_write, 1'b0);
        tick();

        // Continuous competition from both sides
        ifc.inst_mem_read = 1'b1;
        ifc.inst_mem_addr = 32'h700;
        ifc.data_mem_read = 1'b1;
        ifc.data_mem_addr = 32'h800;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            if ((k % 5) == 4) push(1'b1, 1'b0, 32'h700, 256'h0);
            else              push(1'b0, 1'b0, 32'h800, 256'h0);
`else
            push(1'b0, 1'b0, 32'h800, 256'h0);
`endif
            serve(1, {8{k[31:0] ^ 32'h0F0F_0F0F}}, 1'b0);
        end
        ifc.inst_mem_read = 1'b0;
        ifc.data_mem_read = 1'b0;
        repeat (3) tick();
        chk("final_idle", ifc.mem_read | ifc.mem_write, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_sched_arbiter.md
MEM_SCHED_ARBITER -- requirements
Module: mem_sched_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port inst_mem_read  input  1  I-cache line fill request.
REQ-005 SHALL have port inst_mem_addr  input  32  I-cache line address.
REQ-006 SHALL have port inst_mem_rdata  output  256  line returned to I-cache.
REQ-007 SHALL have port inst_mem_resp  output  1  I-cache completion pulse.
REQ-008 SHALL have ports data_mem_read / data_mem_write  input  1 each  D-cache fill / writeback request.
REQ-009 SHALL have port data_mem_addr  input  32, and port data_mem_wdata  input  256  writeback line.
REQ-010 SHALL have port data_mem_rdata  output  256, and port data_mem_resp  output  1  D-cache completion pulse.
REQ-011 SHALL have ports mem_read / mem_write  output  1 each, mem_address  output  32, mem_wdata  output  256  toward cacheline adaptor.
REQ-012 SHALL have ports mem_rdata  input  256, mem_resp  input  1  from cacheline adaptor.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, RECOVER.
REQ-014 IDLE: data request pending -> GRANT_D; else inst pending -> GRANT_I; else stay; decision registered, so mem_read/mem_write assert the cycle after the request is sampled.
REQ-015 On grant SHALL latch address, wdata and op (read/write) into registers; mem_* outputs driven only from these registers.
REQ-016 data_mem_read and data_mem_write both high SHALL be treated as write (mem_write=1, mem_read=0).
REQ-017 mem_read/mem_write SHALL hold stable until the cycle mem_resp=1, then deassert on the next edge.
REQ-018 Granted requester's resp SHALL equal mem_resp combinationally for that single cycle; the other resp stays 0; rdata outputs pass mem_rdata through.
REQ-019 After mem_resp SHALL go to RECOVER for one cycle (no new grant) so requesters can drop their request, then IDLE.
REQ-020 Requester deasserting mid-grant SHALL NOT abort; transaction completes and resp still pulses.
REQ-021 mem_resp outside GRANT_I/GRANT_D SHALL be ignored.
REQ-022 Latency idle-to-adaptor-request SHALL be exactly 1 cycle; back-to-back grants separated by RECOVER (min 1 idle cycle).

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, both resp=0, starvation counter=0.
REQ-024 Reset mid-transaction SHALL abandon the transaction; no resp issued afterward for it.

Configuration
REQ-025 With ARB_STARVE_GUARD_EN defined: counter increments on each data grant while inst_mem_read high, clears on inst grant or when inst_mem_read low in IDLE; when counter == STARVE_LIMIT and inst pending, IDLE SHALL grant inst over data.
REQ-026 Without ARB_STARVE_GUARD_EN: no counter; strict data priority per REQ-014.

Structure
REQ-027 State enum, line width 256 and address width 32 SHALL live in shared package mem_arb_pkg.
REQ-028 Starvation counter SHALL be sub-module arb_starve_ctr, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-029 Inst read 0x0000_0060 alone, mem_resp after 3 cycles with 0xAA..AA -> mem_read=1 addr 0x60 one cycle after request, inst_mem_resp 1 cycle, inst_mem_rdata=0xAA..AA.
REQ-030 Inst and data read same cycle (0x100, 0x200) -> data served first, RECOVER cycle, then inst at 0x100.
REQ-031 Data read+write both high, addr 0x400, wdata 0x55..55 -> mem_write=1, mem_read=0, mem_wdata=0x55..55.
REQ-032 Guard enabled, STARVE_LIMIT=4, continuous data and inst requests -> grants D,D,D,D,I repeating; guard disabled -> I never granted.
REQ-033 reset_n low during GRANT_D with mem_resp pending -> outputs 0 immediately; late mem_resp produces no data_mem_resp.
REQ-034 Requester drops data_mem_read mid-grant -> mem_read held until mem_resp; data_mem_resp still pulses.
